// File: rtl/can_rx_frame_sequencer_if.sv
// can_rx_frame_sequencer_if: bit-timing strobe/bit in, decoded CAN frame fields and status out
interface can_rx_frame_sequencer_if;
  logic        bitstrobe;
  logic        rx_bit;
  logic        bitstuff;
  logic        dataphase;
  logic [3:0]  pkt_size;
  logic [10:0] id;
  logic [3:0]  dlc;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic [14:0] crc_rx;
  logic        ack_slot;
  logic        frame_valid;
  logic        stuff_error;
  logic        form_error;
  logic        bus_idle;
  modport master (
    output bitstrobe, rx_bit,
    input  bitstuff, dataphase, pkt_size, id, dlc, rx_byte, byte_valid,
           crc_rx, ack_slot, frame_valid, stuff_error, form_error, bus_idle
  );
  modport slave (
    input  bitstrobe, rx_bit,
    output bitstuff, dataphase, pkt_size, id, dlc, rx_byte, byte_valid,
           crc_rx, ack_slot, frame_valid, stuff_error, form_error, bus_idle
  );
endinterface

// File: rtl/can_rx_frame_sequencer.sv
// can_rx_frame_sequencer: CAN 2.0A base-frame receive FSM with de-stuffing and field extraction
module can_rx_frame_sequencer #(
  parameter int IDLE_BITS = 11,
  parameter int IFS_BITS  = 3
) (
  input logic                      clk,
  input logic                      nRST,
  can_rx_frame_sequencer_if.slave  bus
);
  typedef enum logic [3:0] {
    S_RECOVER, S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC,
    S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;
  state_t      r_state, w_state;
  logic [6:0]  r_cnt, w_cnt, w_cnt1;
  logic [2:0]  r_run, w_run;
  logic        r_last, w_last;
  logic        r_bitstuff, w_bitstuff;
  logic        r_dataphase, w_dataphase;
  logic [3:0]  r_pkt_size, w_pkt_size;
  logic [10:0] r_id, w_id;
  logic [3:0]  r_dlc, w_dlc, w_dlc_n, w_pkt_n;
  logic        r_rtr, w_rtr;
  logic [6:0]  r_sh, w_sh;
  logic [7:0]  r_rx_byte, w_rx_byte;
  logic        r_byte_valid, w_byte_valid;
  logic [14:0] r_crc, w_crc;
  logic        r_frame_valid, w_frame_valid;
  logic        r_stuff_error, w_stuff_error;
  logic        r_form_error, w_form_error;
  logic        w_err, w_sof, w_field;
  logic        w_rx;
  assign w_rx    = bus.rx_bit;
  assign w_cnt1  = r_cnt + 7'd1;
  assign w_dlc_n = {r_dlc[2:0], w_rx};
  assign w_pkt_n = (w_dlc_n > 4'd8) ? 4'd8 : w_dlc_n;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state       <= S_RECOVER;
      r_cnt         <= '0;
      r_run         <= '0;
      r_last        <= 1'b0;
      r_bitstuff    <= 1'b0;
      r_dataphase   <= 1'b0;
      r_pkt_size    <= '0;
      r_id          <= '0;
      r_dlc         <= '0;
      r_rtr         <= 1'b0;
      r_sh          <= '0;
      r_rx_byte     <= '0;
      r_byte_valid  <= 1'b0;
      r_crc         <= '0;
      r_frame_valid <= 1'b0;
      r_stuff_error <= 1'b0;
      r_form_error  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_run         <= w_run;
      r_last        <= w_last;
      r_bitstuff    <= w_bitstuff;
      r_dataphase   <= w_dataphase;
      r_pkt_size    <= w_pkt_size;
      r_id          <= w_id;
      r_dlc         <= w_dlc;
      r_rtr         <= w_rtr;
      r_sh          <= w_sh;
      r_rx_byte     <= w_rx_byte;
      r_byte_valid  <= w_byte_valid;
      r_crc         <= w_crc;
      r_frame_valid <= w_frame_valid;
      r_stuff_error <= w_stuff_error;
      r_form_error  <= w_form_error;
    end
  end
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_run         = r_run;
    w_last        = r_last;
    w_bitstuff    = r_bitstuff;
    w_dataphase   = r_dataphase;
    w_pkt_size    = r_pkt_size;
    w_id          = r_id;
    w_dlc         = r_dlc;
    w_rtr         = r_rtr;
    w_sh          = r_sh;
    w_rx_byte     = r_rx_byte;
    w_crc         = r_crc;
    w_byte_valid  = 1'b0;
    w_frame_valid = 1'b0;
    w_stuff_error = 1'b0;
    w_form_error  = 1'b0;
    w_err         = 1'b0;
    w_sof         = 1'b0;
    w_field       = 1'b0;
    if (bus.bitstrobe) begin
      if (r_bitstuff) begin
        // stuff bit: consumed here, never reaches a field
        if (w_rx == r_last) begin
          w_stuff_error = 1'b1;
          w_err         = 1'b1;
        end else begin
          w_run      = 3'd1;
          w_last     = w_rx;
          w_bitstuff = 1'b0;
        end
      end else begin
        w_field = r_state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
        case (r_state)
          S_RECOVER: begin
            w_cnt = w_rx ? w_cnt1 : 7'd0;
            if (w_rx && w_cnt1 == 7'(IDLE_BITS)) begin
              w_state = S_IDLE;
              w_cnt   = '0;
            end
          end
          S_IDLE: w_sof = !w_rx;
          S_ID: begin
            w_id  = {r_id[9:0], w_rx};
            w_cnt = w_cnt1;
            if (r_cnt == 7'd10) begin
              w_state = S_RTR;
              w_cnt   = '0;
            end
          end
          S_RTR: begin
            w_rtr   = w_rx;
            w_state = S_IDE;
          end
          S_IDE: begin
            w_err   = w_rx;
            w_state = S_R0;
          end
          S_R0: begin
            w_err   = w_rx;
            w_state = S_DLC;
          end
          S_DLC: begin
            w_dlc = w_dlc_n;
            w_cnt = w_cnt1;
            if (r_cnt == 7'd3) begin
              w_cnt       = '0;
              w_pkt_size  = w_pkt_n;
              w_dataphase = !(r_rtr || w_pkt_n == 4'd0);
              w_state     = w_dataphase ? S_DATA : S_CRC;
            end
          end
          S_DATA: begin
            w_sh  = {r_sh[5:0], w_rx};
            w_cnt = w_cnt1;
            if (r_cnt[2:0] == 3'd7) begin
              w_rx_byte    = {r_sh, w_rx};
              w_byte_valid = 1'b1;
            end
            if (w_cnt1 == {r_pkt_size, 3'b000}) begin
              w_state     = S_CRC;
              w_cnt       = '0;
              w_dataphase = 1'b0;
            end
          end
          S_CRC: begin
            w_crc = {r_crc[13:0], w_rx};
            w_cnt = w_cnt1;
            if (r_cnt == 7'd14) begin
              w_state = S_CRC_DEL;
              w_cnt   = '0;
            end
          end
          S_CRC_DEL: begin
            w_err   = !w_rx;
            w_state = S_ACK;
          end
          S_ACK: w_state = S_ACK_DEL;
          S_ACK_DEL: begin
            w_err   = !w_rx;
            w_state = S_EOF;
            w_cnt   = '0;
          end
          S_EOF: begin
            w_err = !w_rx;
            w_cnt = w_cnt1;
            if (r_cnt == 7'd6) begin
              w_frame_valid = w_rx;
              w_state       = S_IFS;
              w_cnt         = '0;
            end
          end
          S_IFS: begin
            w_sof = !w_rx;
            w_cnt = w_cnt1;
            if (w_cnt1 == 7'(IFS_BITS)) begin
              w_state = S_IDLE;
              w_cnt   = '0;
            end
          end
          default: w_state = S_RECOVER;
        endcase
        w_form_error = w_err;
        if (w_sof) begin
          w_state = S_ID;
          w_cnt   = '0;
          w_run   = 3'd1;
          w_last  = 1'b0;
        end
        if (w_field) begin
          w_run      = (w_rx == r_last) ? r_run + 3'd1 : 3'd1;
          w_last     = w_rx;
          w_bitstuff = (w_run == 3'd5);
        end
      end
      if (w_err) begin
        w_state       = S_RECOVER;
        w_cnt         = '0;
        w_dataphase   = 1'b0;
        w_bitstuff    = 1'b0;
        w_pkt_size    = '0;
        w_frame_valid = 1'b0;
      end
    end
  end
  assign bus.bitstuff    = r_bitstuff;
  assign bus.dataphase   = r_dataphase;
  assign bus.pkt_size    = r_pkt_size;
  assign bus.id          = r_id;
  assign bus.dlc         = r_dlc;
  assign bus.rx_byte     = r_rx_byte;
  assign bus.byte_valid  = r_byte_valid;
  assign bus.crc_rx      = r_crc;
  assign bus.ack_slot    = (r_state == S_ACK);
  assign bus.frame_valid = r_frame_valid;
  assign bus.stuff_error = r_stuff_error;
  assign bus.form_error  = r_form_error;
  assign bus.bus_idle    = (r_state == S_IDLE);
endmodule

// File: tb/tb_can_rx_frame_sequencer.sv
// tb_can_rx_frame_sequencer: directed CAN frames with expected events queued and checked by a monitor
module tb_can_rx_frame_sequencer;
  typedef struct {
    int          kind;
    logic [33:0] val;
  } evt_t;
  localparam int K_BYTE = 0, K_FRAME = 1, K_STUFF = 2, K_FORM = 3, K_IDLE = 4;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   dp_cnt, ack_cnt;
  logic prev_idle = 1'b0;
  evt_t sb[$];
  bit   raw[$];
  bit   txq[$];
  can_rx_frame_sequencer_if bus();
  can_rx_frame_sequencer #(.IDLE_BITS(11), .IFS_BITS(3)) dut (.clk(clk), .nRST(nRST), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic exp_evt(input int k, input logic [33:0] v);
    evt_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask
  task automatic check_evt(input int k, input logic [33:0] v);
    evt_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d val=%h, required no event", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val !== v) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%h, required kind=%0d val=%h", k, v, e.kind, e.val);
      end
    end
  endtask
  always @(negedge clk) begin
    if (nRST) begin
      if (bus.byte_valid)  check_evt(K_BYTE, {26'd0, bus.rx_byte});
      if (bus.frame_valid) check_evt(K_FRAME, {bus.crc_rx, bus.id, bus.dlc, bus.pkt_size});
      if (bus.stuff_error) check_evt(K_STUFF, 34'd0);
      if (bus.form_error)  check_evt(K_FORM, 34'd0);
      if (bus.bus_idle && !prev_idle) check_evt(K_IDLE, 34'd0);
      prev_idle = bus.bus_idle;
    end
  end
  task automatic strobe(input bit b);
    @(negedge clk);
    if (bus.dataphase) dp_cnt++;
    if (bus.ack_slot) ack_cnt++;
    bus.bitstrobe = 1'b1;
    bus.rx_bit    = b;
    @(negedge clk);
    bus.bitstrobe = 1'b0;
    bus.rx_bit    = 1'b1;
    #1;
  endtask
  task automatic ones(input int n);
    for (int i = 0; i < n; i++) strobe(1'b1);
  endtask
  task automatic push_field(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) raw.push_back(v[i]);
  endtask
  task automatic build(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                       input int nb, input logic [63:0] data, input logic [14:0] crc);
    int run;
    bit last;
    raw = {};
    txq = {};
    raw.push_back(1'b0);
    push_field(32'(id), 11);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    push_field(32'(dlc), 4);
    for (int b = 0; b < nb; b++) push_field(32'(data[63 - 8*b -: 8]), 8);
    push_field(32'(crc), 15);
    run  = 0;
    last = 1'b0;
    foreach (raw[i]) begin
      txq.push_back(raw[i]);
      run  = (i > 0 && raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin
        txq.push_back(!last);
        last = !last;
        run  = 1;
      end
    end
  endtask
  task automatic add_tail();
    txq.push_back(1'b1);
    txq.push_back(1'b0);
    for (int i = 0; i < 11; i++) txq.push_back(1'b1);
  endtask
  task automatic run_frame(input int dp_exp, input int sc);
    int n;
    n       = txq.size();
    dp_cnt  = 0;
    ack_cnt = 0;
    for (int i = 0; i < n; i++) begin
      strobe(txq[i]);
      if (i == sc - 1) chk("bitstuff_after_run5", 64'(bus.bitstuff), 64'd1);
      if (i == n - 5)  chk("pending_after_eof6", 64'(sb.size()), 64'd2);
      if (i == n - 4)  chk("pending_after_eof7", 64'(sb.size()), 64'd1);
      if (i == n - 2)  chk("idle_after_ifs2", 64'(bus.bus_idle), 64'd0);
    end
    chk("idle_after_ifs3", 64'(bus.bus_idle), 64'd1);
    chk("dataphase_strobes", 64'(dp_cnt), 64'(dp_exp));
    chk("ack_strobes", 64'(ack_cnt), 64'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end
  initial begin
    bus.bitstrobe = 1'b0;
    bus.rx_bit    = 1'b1;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    #1;
    chk("rst_bus_idle", 64'(bus.bus_idle), 64'd0);
    chk("rst_outputs", {bus.bitstuff, bus.dataphase, bus.pkt_size, bus.id, bus.dlc, bus.rx_byte, bus.crc_rx, bus.ack_slot}, 64'd0);
    ones(5);
    strobe(1'b0);
    ones(10);
    chk("idle_after_10", 64'(bus.bus_idle), 64'd0);
    exp_evt(K_IDLE, 34'd0);
    ones(1);
    chk("idle_after_11", 64'(bus.bus_idle), 64'd1);
    build(11'h123, 1'b0, 4'd1, 1, 64'hA500_0000_0000_0000, 15'h555F);
    add_tail();
    exp_evt(K_BYTE, 34'hA5);
    exp_evt(K_FRAME, {15'h555F, 11'h123, 4'd1, 4'd1});
    exp_evt(K_IDLE, 34'd0);
    run_frame(8, 0);
    build(11'h000, 1'b0, 4'd0, 0, 64'd0, 15'h2AAA);
    add_tail();
    exp_evt(K_FRAME, {15'h2AAA, 11'h000, 4'd0, 4'd0});
    exp_evt(K_IDLE, 34'd0);
    run_frame(0, 5);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    chk("bitstuff_before_bad_stuff", 64'(bus.bitstuff), 64'd1);
    exp_evt(K_STUFF, 34'd0);
    strobe(1'b0);
    chk("stuff_err_idle", 64'(bus.bus_idle), 64'd0);
    chk("stuff_err_bitstuff", 64'(bus.bitstuff), 64'd0);
    exp_evt(K_IDLE, 34'd0);
    ones(11);
    chk("stuff_err_recovered", 64'(bus.bus_idle), 64'd1);
    build(11'h555, 1'b0, 4'hF, 8, 64'h0102_0304_0506_0708, 15'h1B3C);
    add_tail();
    for (int b = 1; b <= 8; b++) exp_evt(K_BYTE, 34'(b));
    exp_evt(K_FRAME, {15'h1B3C, 11'h555, 4'hF, 4'd8});
    exp_evt(K_IDLE, 34'd0);
    run_frame(71, 0);
    build(11'h0F0, 1'b0, 4'd2, 2, 64'h33CC_0000_0000_0000, 15'h0101);
    txq.push_back(1'b0);
    exp_evt(K_BYTE, 34'h33);
    exp_evt(K_BYTE, 34'hCC);
    exp_evt(K_FORM, 34'd0);
    foreach (txq[i]) strobe(txq[i]);
    chk("form_err_dataphase", 64'(bus.dataphase), 64'd0);
    chk("form_err_pkt_size", 64'(bus.pkt_size), 64'd0);
    chk("form_err_crc_hold", 64'(bus.crc_rx), 64'h0101);
    chk("form_err_pending", 64'(sb.size()), 64'd0);
    ones(10);
    chk("form_err_idle_10", 64'(bus.bus_idle), 64'd0);
    exp_evt(K_IDLE, 34'd0);
    ones(1);
    chk("form_err_idle_11", 64'(bus.bus_idle), 64'd1);
    build(11'h2A5, 1'b1, 4'd4, 0, 64'd0, 15'h1234);
    add_tail();
    exp_evt(K_FRAME, {15'h1234, 11'h2A5, 4'd4, 4'd4});
    exp_evt(K_IDLE, 34'd0);
    run_frame(0, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
